// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Brief    : Sub-word load/store front end for a word-addressed memory.
//             Checks op legality, alignment and range, extracts and extends
//             load data, and turns byte/half stores into read-modify-write.
//  Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int MEM_ADDR_BITS = 14
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wr_en,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_READ  = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    localparam logic [1:0] c_SIZE_BYTE = 2'b00;
    localparam logic [1:0] c_SIZE_HALF = 2'b01;
    localparam logic [1:0] c_SIZE_WORD = 2'b10;

    state_t      r_state;
    state_t      w_next_state;

    logic [31:0] r_addr_q;
    logic [2:0]  r_op_q;
    logic [15:0] r_wdata_q;
    logic [31:0] r_merge_q;
    logic [31:0] r_rdata_q;
    logic        r_err_q;

    logic        w_accept;
    logic        w_legal;
    logic        w_misaligned;
    logic        w_out_of_range;
    logic        w_req_err;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_merge_data;

    assign w_accept = req_valid && (r_state == S_IDLE);

    // Request checking: op legality depends on direction; range uses the full address.
    always_comb begin
        w_legal = 1'b0;
        case (req_op)
            3'b000, 3'b001, 3'b010: w_legal = 1'b1;
            3'b100, 3'b101:         w_legal = !req_store;
            default:                w_legal = 1'b0;
        endcase
        w_misaligned   = ((req_op[1:0] == c_SIZE_WORD) && (req_addr[1:0] != 2'b00)) ||
                         ((req_op[1:0] == c_SIZE_HALF) && req_addr[0]);
        w_out_of_range = |req_addr[31:MEM_ADDR_BITS];
        w_req_err      = !w_legal || w_misaligned || w_out_of_range;
    end

    // Lane extraction and store merge from the currently addressed memory word.
    always_comb begin
        w_byte       = mem_rdata[{r_addr_q[1:0], 3'b000} +: 8];
        w_half       = mem_rdata[{r_addr_q[1], 4'b0000} +: 16];
        w_load_data  = mem_rdata;
        w_merge_data = mem_rdata;
        case (r_op_q[1:0])
            c_SIZE_BYTE: begin
                w_load_data = {{24{!r_op_q[2] && w_byte[7]}}, w_byte};
                w_merge_data[{r_addr_q[1:0], 3'b000} +: 8] = r_wdata_q[7:0];
            end
            c_SIZE_HALF: begin
                w_load_data = {{16{!r_op_q[2] && w_half[15]}}, w_half};
                w_merge_data[{r_addr_q[1], 4'b0000} +: 16] = r_wdata_q;
            end
            default: begin
                w_load_data  = mem_rdata;
                w_merge_data = mem_rdata;
            end
        endcase
    end

    // Next-state selection for the request sequencer.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_req_err)
                        w_next_state = S_RESP;
                    else if (!req_store)
                        w_next_state = S_LOAD;
                    else if (req_op[1:0] == c_SIZE_WORD)
                        w_next_state = S_WRITE;
                    else
                        w_next_state = S_READ;
                end
            end
            S_LOAD:  w_next_state = S_RESP;
            S_READ:  w_next_state = S_WRITE;
            S_WRITE: w_next_state = S_RESP;
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    // Datapath registers: request capture, load result and merged store word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr_q  <= '0;
            r_op_q    <= '0;
            r_wdata_q <= '0;
            r_merge_q <= '0;
            r_rdata_q <= '0;
            r_err_q   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_err_q   <= w_req_err;
                        r_rdata_q <= '0;
                        // Rejected requests leave the memory address untouched.
                        if (!w_req_err) begin
                            r_addr_q  <= req_addr;
                            r_op_q    <= req_op;
                            r_wdata_q <= req_wdata[15:0];
                            if (req_store && (req_op[1:0] == c_SIZE_WORD))
                                r_merge_q <= req_wdata;
                        end
                    end
                end
                S_LOAD:  r_rdata_q <= w_load_data;
                S_READ:  r_merge_q <= w_merge_data;
                default: ;
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_err   = (r_state == S_RESP) && r_err_q;
    assign resp_rdata = (r_state == S_RESP) ? r_rdata_q : 32'h0;
    assign mem_addr   = {r_addr_q[31:2], 2'b00};
    assign mem_wdata  = r_merge_q;
    // Reset gates the write strobe so an aborted store never commits.
    assign mem_wr_en  = (r_state == S_WRITE) && !reset;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_store_unit
//  Brief    : Self-checking bench for load_store_unit with a word memory,
//             a behavioural request model and a per-cycle output checker.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam int c_WORDS   = 4096;
    localparam int c_SCHED   = 4096;
    localparam int c_TIMEOUT = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_op = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wr_en;
    logic [31:0] mem_rdata;

    load_store_unit #(.MEM_ADDR_BITS(14)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wr_en  (mem_wr_en),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory seen by the DUT, and the model's own view of memory contents.
    bit [31:0] ram       [c_WORDS];
    bit [31:0] model_mem [c_WORDS];

    assign mem_rdata = ram[mem_addr[13:2]];

    always @(posedge clk) begin
        if (mem_wr_en === 1'b1)
            ram[mem_addr[13:2]] <= mem_wdata;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle expectation schedule, filled when a request is accepted.
    bit        exp_v   [c_SCHED];
    bit        exp_err [c_SCHED];
    bit        exp_we  [c_SCHED];
    bit        busy    [c_SCHED];
    bit [31:0] exp_rd  [c_SCHED];
    bit [31:0] exp_wd  [c_SCHED];
    bit [31:0] exp_wa  [c_SCHED];

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural request model: legality, alignment, range, lanes, latency.
    function automatic void model(input bit st, input bit [2:0] op, input bit [31:0] addr,
                                  input bit [31:0] wd, output bit err, output bit [31:0] rd,
                                  output bit [31:0] nw, output int lat);
        bit        legal;
        int        nb;
        int        sh;
        bit [31:0] mask;
        bit [31:0] word;
        bit [31:0] field;
        if (st) legal = op inside {3'b000, 3'b001, 3'b010};
        else    legal = op inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        nb    = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
        err   = !legal || ((addr % nb) != 0) || (addr >= 32'h4000);
        word  = model_mem[addr[13:2]];
        sh    = 8 * int'(addr % 4);
        mask  = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        field = (word >> sh) & mask;
        rd    = field;
        if (!op[2] && nb < 4 && field >= (32'd1 << (8 * nb - 1)))
            rd = field | ~mask;
        nw  = (word & ~(mask << sh)) | ((wd & mask) << sh);
        lat = err ? 1 : (!st ? 2 : (nb == 4 ? 2 : 3));
        if (err) begin
            rd = 32'h0;
            nw = word;
        end
        if (st) rd = 32'h0;
    endfunction

    // Per-cycle compare of every DUT output against the schedule.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", 32'(req_ready), 32'(!busy[cyc]));
            chk("resp_valid", 32'(resp_valid), 32'(exp_v[cyc]));
            if (exp_v[cyc]) begin
                chk("resp_rdata", resp_rdata, exp_rd[cyc]);
                chk("resp_err", 32'(resp_err), 32'(exp_err[cyc]));
            end
            chk("mem_wr_en", 32'(mem_wr_en), 32'(exp_we[cyc]));
            if (exp_we[cyc]) begin
                chk("mem_wdata", mem_wdata, exp_wd[cyc]);
                chk("mem_addr", mem_addr, exp_wa[cyc]);
            end
        end
    end

    // Present a request until accepted, then schedule its expected outputs.
    task automatic issue(input bit st, input bit [2:0] op, input bit [31:0] addr,
                         input bit [31:0] wd, input bit abort, input bit has_lit,
                         input bit [31:0] lit, output int acc);
        bit        rdy;
        bit        err;
        bit [31:0] rd;
        bit [31:0] nw;
        int        lat;
        req_valid = 1'b1;
        req_store = st;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        acc = -1;
        for (int i = 0; i < c_TIMEOUT; i++) begin
            @(negedge clk);
            rdy = req_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                acc = cyc - 1;
                break;
            end
        end
        if (acc < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: got no accept expected accept within %0d cycles", c_TIMEOUT);
            return;
        end
        model(st, op, addr, wd, err, rd, nw, lat);
        if (abort) begin
            busy[acc + 1] = 1'b1;
            busy[acc + 2] = 1'b1;
        end else begin
            for (int c = 1; c <= lat; c++) busy[acc + c] = 1'b1;
            exp_v[acc + lat]   = 1'b1;
            exp_rd[acc + lat]  = rd;
            exp_err[acc + lat] = err;
            if (st && !err) begin
                exp_we[acc + lat - 1] = 1'b1;
                exp_wd[acc + lat - 1] = nw;
                exp_wa[acc + lat - 1] = {addr[31:2], 2'b00};
                model_mem[addr[13:2]] = nw;
            end
        end
        if (has_lit) chk("model_pin", st ? nw : rd, lit);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int a;
        int a1;
        int a2;
        for (int i = 0; i < c_WORDS; i++) ram[i] = 32'h5A00_0000 ^ (i * 32'h0001_0203);
        ram[4]  = 32'h80FF_7F01;
        ram[8]  = 32'h1122_3344;
        ram[10] = 32'h0BAD_F00D;
        for (int i = 0; i < c_WORDS; i++) model_mem[i] = ram[i];

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'h1);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_err", 32'(resp_err), 32'h0);
        chk("rst_mem_wr_en", 32'(mem_wr_en), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        @(posedge clk);
        #1 chk_en = 1'b1;

        // Loads with sign and zero extension.
        issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 1'b1, 32'h80FF_7F01, a); idle(3);
        issue(1'b0, 3'b000, 32'h13, 32'h0, 1'b0, 1'b1, 32'hFFFF_FF80, a); idle(3);
        issue(1'b0, 3'b100, 32'h13, 32'h0, 1'b0, 1'b1, 32'h0000_0080, a); idle(3);
        issue(1'b0, 3'b001, 32'h12, 32'h0, 1'b0, 1'b1, 32'hFFFF_80FF, a); idle(3);
        issue(1'b0, 3'b101, 32'h10, 32'h0, 1'b0, 1'b1, 32'h0000_7F01, a); idle(3);

        // Read-modify-write stores.
        issue(1'b1, 3'b000, 32'h21, 32'h0000_00AB, 1'b0, 1'b1, 32'h1122_AB44, a); idle(4);
        issue(1'b1, 3'b001, 32'h22, 32'h0000_BEEF, 1'b0, 1'b1, 32'hBEEF_AB44, a); idle(4);
        issue(1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 1'b1, 32'hBEEF_AB44, a); idle(3);

        // Rejected requests.
        issue(1'b0, 3'b010, 32'h06,   32'h0, 1'b0, 1'b0, 32'h0, a); idle(3);
        issue(1'b1, 3'b001, 32'h03,   32'h1234, 1'b0, 1'b0, 32'h0, a); idle(3);
        issue(1'b0, 3'b000, 32'h4000, 32'h0, 1'b0, 1'b0, 32'h0, a); idle(3);
        issue(1'b1, 3'b100, 32'h24,   32'h55, 1'b0, 1'b0, 32'h0, a); idle(3);

        // Reset during the write cycle of a byte store.
        issue(1'b1, 3'b000, 32'h28, 32'h0000_0077, 1'b1, 1'b0, 32'h0, a);
        req_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        idle(3);
        chk("abort_no_write", ram[10], 32'h0BAD_F00D);

        // Back-to-back store then load with req_valid held high.
        issue(1'b1, 3'b010, 32'h30, 32'hCAFE_F00D, 1'b0, 1'b1, 32'hCAFE_F00D, a1);
        issue(1'b0, 3'b010, 32'h30, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D, a2);
        chk("b2b_accept_cycle", 32'(a2), 32'(a1 + 3));
        idle(4);

        chk("final_word_20", ram[8], 32'hBEEF_AB44);
        chk("final_word_30", ram[12], 32'hCAFE_F00D);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
